// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, x/y counters, syncs and a registered colour path.
// Define VGA_TEST_PATTERN_EN to add a test_en input that swaps renderer colour for 8 vertical bars.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int COLOR_W   = 4,
  localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW       = $clog2(H_TOTAL),
  localparam int YW       = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COLOR_W-1:0] pix_r,
  input  logic [COLOR_W-1:0] pix_g,
  input  logic [COLOR_W-1:0] pix_b,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               test_en,
`endif
  output logic [XW-1:0]      x,
  output logic [YW-1:0]      y,
  output logic               active,
  output logic               pix_stb,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FRONT);
  localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FRONT);
  localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FRONT + V_SYNC);

  if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || CLK_DIV < 1) begin : g_param_check
    $error("vga_timing_gen: porch, sync and active sizes and CLK_DIV must all be >= 1");
  end

  logic [DW-1:0]      div;
  logic               hs_region;
  logic               vs_region;
  logic [COLOR_W-1:0] src_r;
  logic [COLOR_W-1:0] src_g;
  logic [COLOR_W-1:0] src_b;

  // pix_stb is registered so the first strobe lands on the CLK_DIV-th edge after reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      pix_stb <= 1'b0;
    end else begin
      pix_stb <= (div == DIV_LAST);
      div     <= (div == DIV_LAST) ? '0 : div + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pix_stb) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  assign active      = (x < X_ACT) && (y < Y_ACT);
  assign line_start  = (x == '0);
  assign frame_start = line_start && (y == '0);
  assign hs_region   = (x >= HS_START) && (x < HS_END);
  assign vs_region   = (y >= VS_START) && (y < VS_END);

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 >= 1) ? H_ACTIVE / 8 : 1;
  int         bar_raw;
  logic [2:0] bar;

  always_comb begin
    bar_raw = int'(x) / BAR_W;
    bar     = (bar_raw > 7) ? 3'd7 : 3'(bar_raw);
  end

  assign src_r = test_en ? {COLOR_W{bar[0]}} : pix_r;
  assign src_g = test_en ? {COLOR_W{bar[1]}} : pix_g;
  assign src_b = test_en ? {COLOR_W{bar[2]}} : pix_b;
`else
  assign src_r = pix_r;
  assign src_g = pix_g;
  assign src_b = pix_b;
`endif

  // Syncs and colour share one pipeline stage so they stay mutually aligned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync <= ~HSYNC_POL;
      vsync <= ~VSYNC_POL;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_stb) begin
      hsync <= hs_region ? HSYNC_POL : ~HSYNC_POL;
      vsync <= vs_region ? VSYNC_POL : ~VSYNC_POL;
      red   <= active ? src_r : '0;
      green <= active ? src_g : '0;
      blue  <= active ? src_b : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: two small-geometry instances (CLK_DIV 1 and 3, both
// sync polarities) compared every cycle against a cycle-count arithmetic model, plus a vector table.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int F  = HT * VT;
  localparam int CW = 4;
  localparam int DA = 1;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  bit   tp = 1'b0;

  logic [CW-1:0] pix_a_r, pix_a_g, pix_a_b, pix_b_r, pix_b_g, pix_b_b;
  logic [4:0]    x_a, x_b;
  logic [3:0]    y_a, y_b;
  logic          active_a, pix_stb_a, line_start_a, frame_start_a, hsync_a, vsync_a;
  logic          active_b, pix_stb_b, line_start_b, frame_start_b, hsync_b, vsync_b;
  logic [CW-1:0] red_a, green_a, blue_a, red_b, green_b, blue_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CLK_DIV(DA), .COLOR_W(CW)
  ) dut_a (
    .clk(clk), .reset(reset), .pix_r(pix_a_r), .pix_g(pix_a_g), .pix_b(pix_a_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(tp),
`endif
    .x(x_a), .y(y_a), .active(active_a), .pix_stb(pix_stb_a), .line_start(line_start_a),
    .frame_start(frame_start_a), .hsync(hsync_a), .vsync(vsync_a),
    .red(red_a), .green(green_a), .blue(blue_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CLK_DIV(DB), .COLOR_W(CW)
  ) dut_b (
    .clk(clk), .reset(reset), .pix_r(pix_b_r), .pix_g(pix_b_g), .pix_b(pix_b_b),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .x(x_b), .y(y_b), .active(active_b), .pix_stb(pix_stb_b), .line_start(line_start_b),
    .frame_start(frame_start_b), .hsync(hsync_b), .vsync(vsync_b),
    .red(red_b), .green(green_b), .blue(blue_b)
  );

  typedef struct {
    int x; int y;
    bit act; bit ls; bit fs; bit stb; bit hs; bit vs;
    logic [CW-1:0] r; logic [CW-1:0] g; logic [CW-1:0] b;
  } exp_t;

  typedef struct {
    int n; int x; int y;
    bit act; bit ls; bit fs; bit hs; bit vs;
  } vec_t;

  logic [3*CW-1:0] ctab [F];
  int n;
  int total = 0;
  int bad = 0;

  // Pixel index reached after n clock edges since reset release
  function automatic int pidx(input int cyc, input int d);
    return (cyc == 0) ? 0 : (cyc - 1) / d;
  endfunction

  function automatic exp_t model(input int cyc, input int d, input bit hpol, input bit vpol, input bit tpe);
    exp_t e;
    int p, q, qx, qy, bar;
    p     = pidx(cyc, d);
    e.x   = p % HT;
    e.y   = (p / HT) % VT;
    e.act = (e.x < HA) && (e.y < VA);
    e.ls  = (e.x == 0);
    e.fs  = e.ls && (e.y == 0);
    e.stb = (cyc >= 1) && (cyc % d == 0);
    e.hs  = ~hpol;
    e.vs  = ~vpol;
    e.r   = '0; e.g = '0; e.b = '0;
    if (p >= 1) begin
      q  = p - 1;
      qx = q % HT;
      qy = (q / HT) % VT;
      if (qx >= HA + HF && qx < HA + HF + HS) e.hs = hpol;
      if (qy >= VA + VF && qy < VA + VF + VS) e.vs = vpol;
      if (qx < HA && qy < VA) begin
        if (tpe) begin
          bar = qx / (HA / 8);
          if (bar > 7) bar = 7;
          e.r = {CW{bar[0]}};
          e.g = {CW{bar[1]}};
          e.b = {CW{bar[2]}};
        end else begin
          {e.r, e.g, e.b} = ctab[q % F];
        end
      end
    end
    return e;
  endfunction

  task automatic check_value(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s n=%0d got=%h want=%h", name, n, actual, expected);
    end
  endtask

  task automatic check_output(input bit sel_b);
    exp_t e;
    logic [26:0] act_v, exp_v;
    if (sel_b) begin
      e = model(n, DB, 1'b1, 1'b1, 1'b0);
      act_v = {x_b, y_b, active_b, line_start_b, frame_start_b, pix_stb_b, hsync_b, vsync_b, red_b, green_b, blue_b};
    end else begin
      e = model(n, DA, 1'b0, 1'b0, tp);
      act_v = {x_a, y_a, active_a, line_start_a, frame_start_a, pix_stb_a, hsync_a, vsync_a, red_a, green_a, blue_a};
    end
    exp_v = {5'(e.x), 4'(e.y), e.act, e.ls, e.fs, e.stb, e.hs, e.vs, e.r, e.g, e.b};
    check_value(sel_b ? "model_b" : "model_a", 32'(act_v), 32'(exp_v));
  endtask

  task automatic apply_stimulus();
    {pix_a_r, pix_a_g, pix_a_b} = ctab[pidx(n, DA) % F];
    {pix_b_r, pix_b_g, pix_b_b} = ctab[pidx(n, DB) % F];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    n++;
    apply_stimulus();
    check_output(1'b0);
    check_output(1'b1);
  endtask

  task automatic check_reset_state(input string name);
    check_value(name,
      {x_a, y_a, pix_stb_a, hsync_a, vsync_a, red_a, x_b, y_b, pix_stb_b, hsync_b, vsync_b, blue_b},
      {5'd0, 4'd0, 1'b0, 1'b1, 1'b1, 4'd0, 5'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0});
  endtask

  task automatic do_reset(input bit tp_val);
    reset = 1'b1;
    tp = tp_val;
    for (int i = 0; i < F; i++) ctab[i] = 12'($urandom);
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset_state");
    reset = 1'b0;
    n = 0;
    apply_stimulus();
    check_output(1'b0);
    check_output(1'b1);
  endtask

  task automatic measure_hsync(input bit sel_b, input int exp_lat, input int exp_w);
    int c, lat, w;
    c = 0; lat = 0; w = 0;
    while ((sel_b ? line_start_b : line_start_a) && c < 200) begin step(); c++; end
    while (!(sel_b ? line_start_b : line_start_a) && c < 400) begin step(); c++; end
    while ((sel_b ? hsync_b : ~hsync_a) == 1'b0 && lat < 200) begin step(); lat++; end
    while ((sel_b ? hsync_b : ~hsync_a) == 1'b1 && w < 200) begin step(); w++; end
    check_value(sel_b ? "hsync_lat_b" : "hsync_lat_a", 32'(lat), 32'(exp_lat));
    check_value(sel_b ? "hsync_w_b" : "hsync_w_a", 32'(w), 32'(exp_w));
  endtask

  initial begin
    vec_t vecs[$];
    vecs = '{
      '{n:0,   x:0,  y:0, act:1, ls:1, fs:1, hs:1, vs:1},
      '{n:2,   x:1,  y:0, act:1, ls:0, fs:0, hs:1, vs:1},
      '{n:17,  x:16, y:0, act:0, ls:0, fs:0, hs:1, vs:1},
      '{n:20,  x:19, y:0, act:0, ls:0, fs:0, hs:0, vs:1},
      '{n:22,  x:21, y:0, act:0, ls:0, fs:0, hs:0, vs:1},
      '{n:23,  x:22, y:0, act:0, ls:0, fs:0, hs:1, vs:1},
      '{n:25,  x:0,  y:1, act:1, ls:1, fs:0, hs:1, vs:1},
      '{n:145, x:0,  y:6, act:0, ls:1, fs:0, hs:1, vs:1},
      '{n:169, x:0,  y:7, act:0, ls:1, fs:0, hs:1, vs:1},
      '{n:170, x:1,  y:7, act:0, ls:0, fs:0, hs:1, vs:0},
      '{n:217, x:0,  y:9, act:0, ls:1, fs:0, hs:1, vs:0},
      '{n:218, x:1,  y:9, act:0, ls:0, fs:0, hs:1, vs:1},
      '{n:241, x:0,  y:0, act:1, ls:1, fs:1, hs:1, vs:1}
    };

    #1 reset = 1'b1;
    do_reset(1'b0);

    // Hand-computed raster points on the CLK_DIV=1 instance
    foreach (vecs[i]) begin
      while (n < vecs[i].n) step();
      check_value("vector",
        {x_a, y_a, active_a, line_start_a, frame_start_a, hsync_a, vsync_a},
        {5'(vecs[i].x), 4'(vecs[i].y), vecs[i].act, vecs[i].ls, vecs[i].fs, vecs[i].hs, vecs[i].vs});
    end

    measure_hsync(1'b0, (HA + HF + 1) * DA, HS * DA);
    measure_hsync(1'b1, (HA + HF + 1) * DB, HS * DB);

    // Reset mid-frame with the clock low: everything must clear without an edge
    do_reset(1'b0);
    while (n < 3 * HT + 5 + 1) step();
    #2 reset = 1'b1;
    #1 check_reset_state("async_reset");
    check_value("async_reset_rgb", {red_a, green_a, blue_a, red_b, green_b}, 32'd0);
    do_reset(1'b0);
    repeat (2 * F * DB) step();

    for (int k = 0; k < 3; k++) begin
      int len;
      len = int'($urandom_range(50, 900));
      repeat (len) step();
      do_reset(1'b0);
    end
    repeat (F * DB) step();

`ifdef VGA_TEST_PATTERN_EN
    do_reset(1'b1);
    repeat (F + 10) step();
    tp = 1'b0;
`endif

    $display("[TB] test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
